// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - coefficient addresses, sequencer state encoding and channel slice helper
`ifndef FILTER_PKG_SV
`define FILTER_PKG_SV

`define FLT_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package filter_pkg;

  localparam logic [2:0] COEF_A0  = 3'd0;
  localparam logic [2:0] COEF_A1  = 3'd1;
  localparam logic [2:0] COEF_A2  = 3'd2;
  localparam logic [2:0] COEF_B0  = 3'd3;
  localparam logic [2:0] COEF_B1  = 3'd4;
  localparam int         NUM_COEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

`endif

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - programmable sample divider producing a registered one-cycle tick
module sample_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  // A shrunk divisor below the running count restarts the count without ticking.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr || i_div == '0) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == i_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else if (r_cnt > i_div) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/filter_seq_ctrl.sv
// rtl/filter_seq_ctrl.sv - filter bank sequencer: tick snapshot, fire, latency wait, result drain, coefficient bank
import filter_pkg::*;

module filter_seq_ctrl #(
  parameter int N     = 16,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int LAT   = 2,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] sample_div,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [NCH*N-1:0] x_in,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [N-1:0]     cfg_wdata,
  input  logic             cfg_commit,
  input  logic [NCH*N-1:0] flt_y,
  output logic             flt_rst,
  output logic [NCH-1:0]   flt_en,
  output logic [NCH*N-1:0] flt_x,
  output logic [N-1:0]     flt_a0,
  output logic [N-1:0]     flt_a1,
  output logic [N-1:0]     flt_a2,
  output logic [N-1:0]     flt_b0,
  output logic [N-1:0]     flt_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic [CHW-1:0]   res_ch,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e           r_state;
  state_e           w_next;
  logic             w_tick;
  logic             w_apply;
  logic [CHW-1:0]   w_ch;
  logic [NCH-1:0]   w_pend_next;
  logic [NCH-1:0]   r_en_snap;
  logic [NCH-1:0]   r_pend;
  logic [NCH*N-1:0] r_x;
  logic [NCH*N-1:0] r_y;
  logic [WCW-1:0]   r_wait;
  logic [N-1:0]     r_shadow [NUM_COEF];
  logic [N-1:0]     r_active [NUM_COEF];
  logic             r_commit_pend;
  logic             r_flt_rst;
  logic             r_overrun;

  sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (clr),
    .i_div  (sample_div),
    .o_tick (w_tick)
  );

  // r_pend holds the channels still to drain; the lowest one is presented.
  always_comb begin
    w_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pend[i]) w_ch = CHW'(i);
    end
    w_pend_next = r_pend & ~(NCH'(1) << w_ch);
  end

  assign w_apply = (r_state == ST_IDLE) && w_tick && r_commit_pend && !clr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_tick && ch_enable != '0) w_next = ST_FIRE;
      ST_FIRE:  w_next = ST_WAIT;
      ST_WAIT:  if (r_wait == '0) w_next = ST_DRAIN;
      ST_DRAIN: if (res_ready && w_pend_next == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (clr) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flt_rst     <= 1'b1;
      r_en_snap     <= '0;
      r_pend        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_wait        <= '0;
      r_commit_pend <= 1'b0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_flt_rst <= clr;
      if (cfg_we && cfg_addr <= COEF_B1) r_shadow[cfg_addr] <= cfg_wdata;
      // A commit landing on the applying tick re-arms for the next one.
      r_commit_pend <= cfg_commit | (r_commit_pend & ~w_apply);
      if (w_apply) r_active <= r_shadow;
      if (w_tick && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (overrun_clr)             r_overrun <= 1'b0;
      if (!clr) begin
        case (r_state)
          ST_IDLE: if (w_tick) begin
            r_x       <= x_in;
            r_en_snap <= ch_enable;
          end
          ST_FIRE: r_wait <= WCW'(LAT - 1);
          ST_WAIT: if (r_wait == '0) begin
            r_y    <= flt_y;
            r_pend <= r_en_snap;
          end else begin
            r_wait <= r_wait - WCW'(1);
          end
          ST_DRAIN: if (res_ready) r_pend <= w_pend_next;
          default: ;
        endcase
      end
    end
  end

  assign flt_rst   = r_flt_rst;
  assign flt_en    = (r_state == ST_FIRE) ? r_en_snap : '0;
  assign flt_x     = r_x;
  assign flt_a0    = r_active[COEF_A0];
  assign flt_a1    = r_active[COEF_A1];
  assign flt_a2    = r_active[COEF_A2];
  assign flt_b0    = r_active[COEF_B0];
  assign flt_b1    = r_active[COEF_B1];
  assign res_valid = (r_state == ST_DRAIN);
  assign res_data  = `FLT_SLICE(r_y, w_ch, N);
  assign res_ch    = w_ch;
  assign busy      = (r_state != ST_IDLE);
  assign overrun   = r_overrun;

endmodule
